mem_arbiter_ctrl: RTL and testbench

//   Parametrised successor to the single-channel memory controller: arbitrates CPU data (load/store)
//   and instruction-fetch requests onto one external bus through a request/ack handshake. Adds byte

---
 rtl/mem_arbiter_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - data/instruction request arbiter onto a single request/ack memory bus
module mem_arbiter_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int FAIR    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_stall,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  output logic                i_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_strb,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                err,
  output logic [2:0]          state
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic       FAIR_EN = (FAIR != 0);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;   // 0 = data port, 1 = instruction port
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              ptr_q, ptr_d;       // 1 = instruction port preferred next

  logic d_any;
  logic grant_data;
  logic finishing;

  assign d_any      = d_read | d_write;
  assign grant_data = d_any & ~(i_req & FAIR_EN & ptr_q);
  assign finishing  = (state_q == S_DONE) || (state_q == S_ERR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    ptr_d     = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (d_any || i_req) begin
          state_d = S_REQ;
          cnt_d   = 8'd0;
          if (grant_data) begin
            owner_d = 1'b0;
            we_d    = ~d_read;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            strb_d  = d_read ? {STRB_W{1'b1}} : d_strb;
          end else begin
            owner_d = 1'b1;
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
            strb_d  = {STRB_W{1'b1}};
          end
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle takes precedence over the timeout.
        if (bus_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (owner_q) i_rdata_d = bus_rdata;
            else         d_rdata_d = bus_rdata;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        ptr_d   = ~owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      ptr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_strb  = strb_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = finishing & ~owner_q;
  assign i_done    = finishing & owner_q;
  assign err       = (state_q == S_ERR);
  assign state     = state_q;
  assign d_stall   = d_any & ~d_done;
  assign i_stall   = i_req & ~i_done;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb/tb_mem_arbiter_ctrl.sv - self-checking bench for mem_arbiter_ctrl
module tb_mem_arbiter_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic        rd, wr, ir;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_addr;
    logic        exp_data;
    logic        exp_err;
    logic [31:0] exp_d_rdata, exp_i_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_read, d_write, i_req;
  logic [31:0] d_addr, d_wdata, i_addr, bus_rdata;
  logic [3:0]  d_strb;
  logic [31:0] d_rdata, i_rdata, bus_addr, bus_wdata;
  logic        d_done, d_stall, i_done, i_stall, bus_req, bus_we, err;
  logic [3:0]  bus_strb;
  logic [2:0]  state;
  logic        ack_drv, auto_ack;
  logic        bus_ack;

  logic        f_d_read, f_i_req;
  logic [31:0] f_d_rdata, f_i_rdata, f_bus_addr, f_bus_wdata;
  logic        f_d_done, f_d_stall, f_i_done, f_i_stall, f_bus_req, f_bus_we, f_err;
  logic [3:0]  f_bus_strb;
  logic [2:0]  f_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bus_ack = ack_drv | (auto_ack & bus_req);

  mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_strb(bus_strb), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err(err), .state(state)
  );

  mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .FAIR(0)) u_fix (
    .clk(clk), .rst(rst),
    .d_read(f_d_read), .d_write(1'b0), .d_addr(32'h0000_0080), .d_wdata(32'h0), .d_strb(4'h0),
    .d_rdata(f_d_rdata), .d_done(f_d_done), .d_stall(f_d_stall),
    .i_req(f_i_req), .i_addr(32'h0000_0900), .i_rdata(f_i_rdata), .i_done(f_i_done),
    .i_stall(f_i_stall),
    .bus_req(f_bus_req), .bus_we(f_bus_we), .bus_addr(f_bus_addr), .bus_wdata(f_bus_wdata),
    .bus_strb(f_bus_strb), .bus_ack(f_bus_req), .bus_rdata(32'hC0DE_0001), .err(f_err),
    .state(f_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic ir,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int delay, input logic [31:0] rdata,
                              input logic ew, input logic [3:0] es, input logic [31:0] ea,
                              input logic ed, input logic ee,
                              input logic [31:0] edr, input logic [31:0] eir);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ir = ir; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.delay = delay; v.rdata = rdata; v.exp_we = ew; v.exp_strb = es; v.exp_addr = ea;
    v.exp_data = ed; v.exp_err = ee; v.exp_d_rdata = edr; v.exp_i_rdata = eir;
    return v;
  endfunction

  task automatic drop_inputs();
    d_read = 0; d_write = 0; i_req = 0; d_addr = 0; d_wdata = 0; d_strb = 0; i_addr = 0;
    ack_drv = 0; auto_ack = 0;
  endtask

  task automatic do_reset();
    drop_inputs();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  // Inputs are applied at a negedge in IDLE; requests and fields are scrambled during REQ.
  task automatic run_txn(input vec_t v);
    int  n;
    bit  fin;
    d_read = v.rd; d_write = v.wr; i_req = v.ir;
    d_addr = v.addr; i_addr = v.addr + 32'h1000; d_wdata = v.wdata; d_strb = v.strb;
    @(negedge clk);
    chk("grant_latency", bus_req, 1);
    n = 1;
    fin = 0;
    while (!fin && n <= TIMEOUT + 2) begin
      chk("req_state", state, 1);
      chk("bus_addr", bus_addr, v.exp_addr);
      chk("bus_we", bus_we, v.exp_we);
      chk("bus_strb", bus_strb, v.exp_strb);
      if (v.exp_we) chk("bus_wdata", bus_wdata, v.wdata);
      chk("no_done_in_req", {d_done, i_done, err}, 0);
      chk("d_stall_req", d_stall, d_read | d_write);
      d_addr = $urandom; i_addr = $urandom; d_wdata = $urandom; d_strb = 4'($urandom);
      d_read = 1'($urandom); d_write = 1'($urandom); i_req = 1'($urandom);
      if (v.delay < TIMEOUT && n == v.delay + 1) begin
        ack_drv = 1; bus_rdata = v.rdata;
      end else begin
        ack_drv = 0; bus_rdata = $urandom;
      end
      @(negedge clk);
      ack_drv = 0;
      if (!bus_req) fin = 1;
      else n++;
    end
    chk("req_cycles", n, v.exp_err ? TIMEOUT : v.delay + 1);
    chk("end_state", state, v.exp_err ? 3 : 2);
    chk("d_done", d_done, v.exp_data);
    chk("i_done", i_done, !v.exp_data);
    chk("err", err, v.exp_err);
    chk("d_stall_done", d_stall, (d_read | d_write) & !v.exp_data);
    chk("i_stall_done", i_stall, i_req & v.exp_data);
    drop_inputs();
    @(negedge clk);
    chk("idle_after", state, 0);
    chk("pulse_one_cycle", {d_done, i_done, err}, 0);
    chk("d_rdata", d_rdata, v.exp_d_rdata);
    chk("i_rdata", i_rdata, v.exp_i_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   order[$];
    int   exp_ord[3] = '{0, 1, 0};
    int   nd, ni;
    bit   found, ptr, rd, wr, ir, dg, we, ee;
    logic [31:0] md, mi, addr, wd, rv;
    logic [3:0]  st, es;
    int   dl;

    f_d_read = 0; f_i_req = 0; bus_rdata = 0;
    drop_inputs();
    rst = 0;
    d_read = 1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_pulses", {d_done, i_done, err}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_release_req", bus_req, 1);
    #2 rst = 0;
    #1;
    chk("midreq_bus_req", bus_req, 0);
    chk("midreq_state", state, 0);
    chk("midreq_done", {d_done, err}, 0);
    @(negedge clk);
    d_read = 0;
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_rst", {d_done, i_done, err}, 0);
    end
    chk("idle_after_rst", state, 0);
    ack_drv = 1; bus_rdata = 32'h1212_1212;
    @(negedge clk);
    ack_drv = 0;
    @(negedge clk);
    chk("idle_ack_ignored_state", state, 0);
    chk("idle_ack_ignored_rdata", d_rdata | i_rdata, 0);

    do_reset();
    tbl.push_back(mk(1,0,0, 32'h40, 32'h0, 4'h0, 2, 32'hDEADBEEF, 0,4'hF, 32'h40,   1,0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0,1,0, 32'h44, 32'h12345678, 4'h3, 0, 32'hCAFE0000, 1,4'h3, 32'h44, 1,0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0,0,1, 32'h100, 32'h0, 4'h0, 1, 32'hA5A50001, 0,4'hF, 32'h1100, 0,0, 32'hDEADBEEF, 32'hA5A50001));
    tbl.push_back(mk(1,0,1, 32'h48, 32'h0, 4'h0, 3, 32'h11112222, 0,4'hF, 32'h48,   1,0, 32'h11112222, 32'hA5A50001));
    tbl.push_back(mk(1,0,1, 32'h4C, 32'h0, 4'h0, 0, 32'h33334444, 0,4'hF, 32'h104C, 0,0, 32'h11112222, 32'h33334444));
    tbl.push_back(mk(1,1,0, 32'h50, 32'h9999, 4'hC, 0, 32'h55556666, 0,4'hF, 32'h50, 1,0, 32'h55556666, 32'h33334444));
    tbl.push_back(mk(1,0,0, 32'h54, 32'h0, 4'h0, 15, 32'h0BADF00D, 0,4'hF, 32'h54,  1,1, 32'h55556666, 32'h33334444));
    tbl.push_back(mk(1,0,0, 32'h58, 32'h0, 4'h0, 14, 32'h77778888, 0,4'hF, 32'h58,  1,0, 32'h77778888, 32'h33334444));
    tbl.push_back(mk(0,0,1, 32'h200, 32'h0, 4'h0, 20, 32'h0, 0,4'hF, 32'h1200,      0,1, 32'h77778888, 32'h33334444));
    tbl.push_back(mk(0,1,1, 32'h60, 32'hAABBCCDD, 4'h5, 1, 32'h0, 1,4'h5, 32'h60,   1,0, 32'h77778888, 32'h33334444));
    tbl.push_back(mk(0,1,1, 32'h64, 32'h0, 4'hF, 0, 32'h44445555, 0,4'hF, 32'h1064, 0,0, 32'h77778888, 32'h44445555));
    foreach (tbl[k]) run_txn(tbl[k]);

    do_reset();
    d_read = 1; d_write = 1; i_req = 1; bus_rdata = 32'h0F0F_0F0F; auto_ack = 1;
    for (int c = 0; c < 20 && order.size() < 3; c++) begin
      @(negedge clk);
      if (bus_req) chk("fair_read_first", bus_we, 0);
      if (d_done) order.push_back(0);
      if (i_done) order.push_back(1);
    end
    drop_inputs();
    chk("fair_count", order.size(), 3);
    for (int k = 0; k < order.size() && k < 3; k++) chk("fair_order", order[k], exp_ord[k]);

    do_reset();
    ptr = 0; md = 0; mi = 0;
    for (int it = 0; it < 60; it++) begin
      rd = 1'($urandom); wr = 1'($urandom); ir = 1'($urandom);
      if (!(rd | wr | ir)) rd = 1;
      addr = $urandom & 32'hFFFF_FFFC; wd = $urandom; st = 4'($urandom); rv = $urandom;
      dl = $urandom_range(0, TIMEOUT + 3);
      dg = (rd | wr) && !(ir && ptr);
      we = dg && !rd;
      es = we ? st : 4'hF;
      ee = (dl >= TIMEOUT);
      if (!ee && !we) begin
        if (dg) md = rv;
        else    mi = rv;
      end
      ptr = dg;
      v = mk(rd, wr, ir, addr, wd, st, dl, rv, we, es, dg ? addr : addr + 32'h1000,
             dg, ee, md, mi);
      run_txn(v);
    end

    f_d_read = 1; f_i_req = 1; nd = 0; ni = 0;
    repeat (30) begin
      @(negedge clk);
      if (f_d_done) nd++;
      if (f_i_done) ni++;
    end
    chk("fixed_prio_fetch_starved", ni, 0);
    chk("fixed_prio_data_served", nd >= 8, 1);
    f_d_read = 0;
    found = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (f_i_done) found = 1;
    end
    chk("fetch_after_data_release", found, 1);
    f_i_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
